inst_buffer: RTL and testbench

INST_BUFFER -- requirements
Module: inst_buffer

---
 rtl/inst_buffer_if.sv | 35 +++
 rtl/inst_buffer.sv | 128 ++++++++++++
 tb/tb_inst_buffer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/inst_buffer_if.sv
// Fetch/dispatch bundle for inst_buffer.
// Handshake: the fetch unit presents fetch_valid/fetch_packets. The group is
// taken in full on a rising clock edge only when enq_accept is high in that
// cycle; otherwise nothing is taken and fetch must hold the same group.
// The decoder sees out_valid/out_packets and consumes dispatch_num head
// packets at the edge. dispatch_num must never exceed popcount(out_valid).
interface inst_buffer_if #(
    parameter int DEPTH = 8,
    parameter int N     = 2,
    parameter int PKT_W = 32
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(N + 1);

    logic                      squash;
    logic [N-1:0]              fetch_valid;
    logic [N-1:0][PKT_W-1:0]   fetch_packets;
    logic [NW-1:0]             dispatch_num;
    logic [N-1:0][PKT_W-1:0]   out_packets;
    logic [N-1:0]              out_valid;
    logic                      enq_accept;
    logic [CW-1:0]             free_slots;

    // Fetch/decode side: drives fetch groups, squash and dispatch count.
    modport master (
        output squash, fetch_valid, fetch_packets, dispatch_num,
        input  out_packets, out_valid, enq_accept, free_slots
    );

    // Buffer side.
    modport slave (
        input  squash, fetch_valid, fetch_packets, dispatch_num,
        output out_packets, out_valid, enq_accept, free_slots
    );
endinterface

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: circular buffer of DEPTH fetch
// packets, up to N enqueued and N dispatched per cycle, zero-latency dequeue.
// Optional macro INST_BUFFER_BYPASS_EN: when the buffer is empty, fetch packets
// are shown on the outputs in the same cycle and only the undispatched
// remainder is stored.
module inst_buffer #(
    parameter int DEPTH = 8,
    parameter int N     = 2,
    parameter int PKT_W = 32
) (
    input logic         clock,
    input logic         reset,
    inst_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(N + 1);

    logic [PKT_W-1:0]        mem [DEPTH];
    logic [PW-1:0]           head_q;
    logic [PW-1:0]           tail_q;
    logic [CW-1:0]           occ_q;

    logic [NW-1:0]           fetch_cnt;
    logic [NW-1:0]           avail;
    logic [NW-1:0]           deq_cnt;
    logic [NW-1:0]           stor_deq;
    logic [NW-1:0]           skip;
    logic [NW-1:0]           enq_cnt;
    logic [CW-1:0]           free_slots;
    logic                    enq_accept;
    logic                    bypass_act;
    logic [N-1:0][PKT_W-1:0] stor_pkts;
    logic [N-1:0]            stor_valid;
    logic [N-1:0][PKT_W-1:0] out_pkts;
    logic [N-1:0]            out_vld;
    logic [N-1:0][PKT_W-1:0] wr_data;

    // Number of packets in the incoming fetch group.
    always_comb begin
        fetch_cnt = '0;
        for (int i = 0; i < N; i++) begin
            fetch_cnt = fetch_cnt + NW'(bus.fetch_valid[i]);
        end
    end

    // Space is judged on registered occupancy only; a same-cycle dequeue
    // never frees room for the current group.
    assign free_slots = CW'(DEPTH) - occ_q;
    assign enq_accept = !bus.squash && !reset && (CW'(fetch_cnt) <= free_slots);

`ifdef INST_BUFFER_BYPASS_EN
    assign bypass_act = (occ_q == '0) && !bus.squash && !reset;
`else
    assign bypass_act = 1'b0;
`endif

    // Head window of the storage in program order.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            stor_pkts[i]  = mem[head_q + PW'(i)];
            stor_valid[i] = (occ_q > CW'(i));
        end
    end

    assign out_pkts = bypass_act ? bus.fetch_packets : stor_pkts;
    assign out_vld  = bypass_act ? bus.fetch_valid   : stor_valid;

    assign bus.out_packets = out_pkts;
    assign bus.out_valid   = out_vld;
    assign bus.enq_accept  = enq_accept;
    assign bus.free_slots  = free_slots;

    // Packets visible to the decoder; illegal dispatch counts are clamped to it.
    always_comb begin
        avail = '0;
        for (int i = 0; i < N; i++) begin
            avail = avail + NW'(out_vld[i]);
        end
    end

    assign deq_cnt  = (bus.dispatch_num > avail) ? avail : bus.dispatch_num;
    // Bypassed packets are consumed straight from fetch and never stored.
    assign stor_deq = bypass_act ? '0 : deq_cnt;
    assign skip     = bypass_act ? deq_cnt : '0;
    assign enq_cnt  = enq_accept ? (fetch_cnt - skip) : '0;

    // Stored packet i comes from fetch slot i+skip (skip past bypassed ones).
    always_comb begin
        wr_data = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == i + int'(skip)) begin
                    wr_data[i] = bus.fetch_packets[j];
                end
            end
        end
    end

    // Pointer and occupancy update; squash and reset discard everything.
    always_ff @(posedge clock) begin
        if (reset || bus.squash) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_q + PW'(stor_deq);
            tail_q <= tail_q + PW'(enq_cnt);
            occ_q  <= occ_q + CW'(enq_cnt) - CW'(stor_deq);
        end
    end

    // Entry writes at tail; entries are never cleared on dequeue.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (NW'(i) < enq_cnt) begin
                mem[tail_q + PW'(i)] <= wr_data[i];
            end
        end
    end

    // Flag decoders asking for more packets than are shown.
    always_ff @(posedge clock) begin
        if (!reset && !bus.squash) begin
            a_dispatch_legal: assert (bus.dispatch_num <= avail);
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer (DEPTH=8, N=2): a driver pushes expected
// packets into exp_q when a group should be accepted; a monitor pops and
// compares every dispatched packet.
module tb_inst_buffer;
    localparam int DEPTH = 8;
    localparam int N     = 2;
    localparam int PKT_W = 32;
`ifdef INST_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [PKT_W-1:0] exp_q[$];

    inst_buffer_if #(.DEPTH(DEPTH), .N(N), .PKT_W(PKT_W)) bus ();

    inst_buffer #(.DEPTH(DEPTH), .N(N), .PKT_W(PKT_W)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.squash        = 1'b0;
        bus.fetch_valid   = '0;
        bus.fetch_packets = '0;
        bus.dispatch_num  = '0;
    endtask

    // One cycle: drive, check accept and current out_valid mid-cycle, advance.
    task automatic step(input logic [1:0] fv, input logic [31:0] p0, input logic [31:0] p1,
                        input logic [1:0] dn, input logic sq, input logic exp_acc,
                        input logic [1:0] exp_ov);
        bus.squash           = sq;
        bus.fetch_valid      = fv;
        bus.fetch_packets[0] = p0;
        bus.fetch_packets[1] = p1;
        bus.dispatch_num     = dn;
        if (exp_acc) begin
            if (fv[0]) exp_q.push_back(p0);
            if (fv[1]) exp_q.push_back(p1);
        end
        @(negedge clk);
        check("enq_accept", 32'(bus.enq_accept), 32'(exp_acc));
        check("out_valid_now", 32'(bus.out_valid), 32'(exp_ov));
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // One reset cycle with a fetch group present; it must be refused.
    task automatic reset_step(input logic [31:0] p0, input logic [31:0] p1);
        reset                = 1'b1;
        bus.fetch_valid      = 2'b11;
        bus.fetch_packets[0] = p0;
        bus.fetch_packets[1] = p1;
        @(negedge clk);
        check("enq_accept_in_reset", 32'(bus.enq_accept), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        exp_q.delete();
    endtask

    task automatic expect_state(input string name, input logic [1:0] ov, input logic [3:0] fs);
        check({name, "_out_valid"}, 32'(bus.out_valid), 32'(ov));
        check({name, "_free_slots"}, 32'(bus.free_slots), 32'(fs));
    endtask

    task automatic expect_pkt(input string name, input int slot, input logic [31:0] pc);
        check(name, bus.out_packets[slot], pc);
    endtask

    // Scoreboard monitor: every dispatched packet must be the next expected.
    always @(negedge clk) begin
        if (!reset && !bus.squash) begin
            for (int i = 0; i < N; i++) begin
                if (i < int'(bus.dispatch_num)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dispatch_underflow: got %0h expected none", bus.out_packets[i]);
                    end else begin
                        check("dispatch_pc", bus.out_packets[i], exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        reset_step(32'hDEAD0000, 32'hDEAD0004);
        reset_step(32'hDEAD0008, 32'hDEAD000C);
        expect_state("after_reset", 2'b00, 4'd8);

        // Two packets in, nothing dispatched.
        step(2'b11, 32'h0, 32'h4, 2'd0, 1'b0, 1'b1, BYP ? 2'b11 : 2'b00);
        expect_state("first_group", 2'b11, 4'd6);
        expect_pkt("first_pc0", 0, 32'h0);
        expect_pkt("first_pc1", 1, 32'h4);

        // Fill to 7.
        step(2'b11, 32'h8,  32'hC,  2'd0, 1'b0, 1'b1, 2'b11);
        step(2'b11, 32'h10, 32'h14, 2'd0, 1'b0, 1'b1, 2'b11);
        step(2'b01, 32'h18, 32'h0,  2'd0, 1'b0, 1'b1, 2'b11);
        expect_state("occ7", 2'b11, 4'd1);

        // Same-cycle dispatch does not make room: refused, occupancy 5.
        step(2'b11, 32'h1C, 32'h20, 2'd2, 1'b0, 1'b0, 2'b11);
        expect_state("refused", 2'b11, 4'd3);
        expect_pkt("refused_head", 0, 32'h8);
        // Retry is accepted: occupancy 7.
        step(2'b11, 32'h1C, 32'h20, 2'd0, 1'b0, 1'b1, 2'b11);
        expect_state("retry", 2'b11, 4'd1);

        // Stream across many pointer wraps, one in and one out per cycle.
        for (int k = 0; k < 20; k++) begin
            step(2'b01, 32'h100 + 32'(4 * k), 32'h0, 2'd1, 1'b0, 1'b1, 2'b11);
        end
        expect_state("stream", 2'b11, 4'd1);

        // Down to 6, then squash with a fetch group and a dispatch.
        step(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b1, 2'b11);
        expect_state("occ6", 2'b11, 4'd2);
        step(2'b11, 32'hBAD0, 32'hBAD4, 2'd2, 1'b1, 1'b0, 2'b11);
        exp_q.delete();
        expect_state("squash", 2'b00, 4'd8);

        // Empty buffer, group 0x40/0x44.
`ifdef INST_BUFFER_BYPASS_EN
        step(2'b11, 32'h40, 32'h44, 2'd1, 1'b0, 1'b1, 2'b11);
        expect_state("bypass", 2'b01, 4'd7);
        expect_pkt("bypass_head", 0, 32'h44);
        step(2'b11, 32'h48, 32'h4C, 2'd0, 1'b0, 1'b1, 2'b01);
        step(2'b11, 32'h50, 32'h54, 2'd0, 1'b0, 1'b1, 2'b11);
`else
        step(2'b11, 32'h40, 32'h44, 2'd0, 1'b0, 1'b1, 2'b00);
        expect_state("no_bypass", 2'b11, 4'd6);
        expect_pkt("no_bypass_head", 0, 32'h40);
        step(2'b11, 32'h48, 32'h4C, 2'd0, 1'b0, 1'b1, 2'b11);
        step(2'b01, 32'h50, 32'h0,  2'd0, 1'b0, 1'b1, 2'b11);
`endif
        expect_state("occ5", 2'b11, 4'd3);

        // Reset mid-stream discards all entries.
        reset_step(32'hBEEF0, 32'hBEEF4);
        expect_state("mid_reset", 2'b00, 4'd8);

        // Buffer works normally afterwards.
        step(2'b11, 32'h60, 32'h64, 2'd0, 1'b0, 1'b1, BYP ? 2'b11 : 2'b00);
        expect_pkt("post_reset_head", 0, 32'h60);
        step(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1, 2'b11);
        expect_state("drained", 2'b00, 4'd8);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
